// File: rtl/eeg_pea_eng_oarb.sv
// ORAM write-port arbiter for the PE array: grants one PE output per cycle and maps it into ORAM space.
// Build option EEG_OARB_FIXED_PRIO_EN: lowest requesting index wins instead of round-robin.
module eeg_pea_eng_oarb #(
  parameter int unsigned PE_NUM      = 8,
  parameter int unsigned DATA_OUT_DW = 8,
  parameter int unsigned OMUX_ADD_AW = 8,
  parameter int unsigned ORAM_ADD_AW = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CFG_START,
  input  logic [PE_NUM-1:0]               CFG_PE_MSK,
  input  logic [ORAM_ADD_AW-1:0]          CFG_ORAM_BAS,
  input  logic [ORAM_ADD_AW-1:0]          CFG_ORAM_STR,
  input  logic [PE_NUM-1:0]               PE_OUT_VLD,
  input  logic [PE_NUM-1:0]               PE_OUT_LST,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0]   PE_OUT_ADD,
  input  logic [PE_NUM*DATA_OUT_DW-1:0]   PE_OUT_DAT,
  output logic [PE_NUM-1:0]               PE_OUT_RDY,
  output logic                            ORAM_WR_VLD,
  output logic [ORAM_ADD_AW-1:0]          ORAM_WR_ADD,
  output logic [DATA_OUT_DW-1:0]          ORAM_WR_DAT,
  input  logic                            ORAM_WR_RDY,
  output logic                            IS_IDLE,
  output logic                            DONE
);

  localparam int unsigned PTR_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_e;

  state_e                  state_q, state_d;
  logic [PE_NUM-1:0]       done_q, done_d;
  logic [PE_NUM-1:0]       req;
  logic [PTR_W-1:0]        win;
  logic                    win_vld;
  logic                    slot_free;
  logic                    accept;
  logic                    wr_vld_q, wr_vld_d;
  logic [ORAM_ADD_AW-1:0]  wr_add_q, wr_add_d;
  logic [DATA_OUT_DW-1:0]  wr_dat_q, wr_dat_d;
  logic [OMUX_ADD_AW-1:0]  sel_add;
  logic [DATA_OUT_DW-1:0]  sel_dat;

  assign slot_free = ~wr_vld_q | ORAM_WR_RDY;
  assign req       = (state_q == ST_RUN) ? (PE_OUT_VLD & CFG_PE_MSK & ~done_q) : '0;

`ifdef EEG_OARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = int'(PE_NUM) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = PTR_W'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;

  // First requester at or after the pointer, wrapping (PE_NUM is a power of 2).
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < int'(PE_NUM); i++) begin
      idx = PTR_W'(int'(ptr_q) + i);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && CFG_START) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = PTR_W'(int'(win) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign accept  = win_vld & slot_free;
  assign sel_add = PE_OUT_ADD[win*OMUX_ADD_AW +: OMUX_ADD_AW];
  assign sel_dat = PE_OUT_DAT[win*DATA_OUT_DW +: DATA_OUT_DW];

  always_comb begin
    PE_OUT_RDY = '0;
    for (int g = 0; g < int'(PE_NUM); g++) begin
      PE_OUT_RDY[g] = accept & (win == PTR_W'(g));
    end
  end

  // Pass control and per-PE completion tracking.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d = ST_RUN;
          done_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept && PE_OUT_LST[win]) begin
          done_d[win] = 1'b1;
        end
        if ((&(done_q | ~CFG_PE_MSK)) && !wr_vld_q) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single output stage; a stalled word holds until ORAM takes it.
  always_comb begin
    wr_vld_d = wr_vld_q;
    wr_add_d = wr_add_q;
    wr_dat_d = wr_dat_q;
    if (accept) begin
      wr_vld_d = 1'b1;
      wr_dat_d = sel_dat;
      wr_add_d = CFG_ORAM_BAS + ORAM_ADD_AW'(win) * CFG_ORAM_STR + ORAM_ADD_AW'(sel_add);
    end else if (ORAM_WR_RDY) begin
      wr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      done_q   <= '0;
      wr_vld_q <= 1'b0;
      wr_add_q <= '0;
      wr_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      wr_vld_q <= wr_vld_d;
      wr_add_q <= wr_add_d;
      wr_dat_q <= wr_dat_d;
    end
  end

  assign ORAM_WR_VLD = wr_vld_q;
  assign ORAM_WR_ADD = wr_add_q;
  assign ORAM_WR_DAT = wr_dat_q;
  assign IS_IDLE     = (state_q == ST_IDLE);
  assign DONE        = (state_q == ST_FIN);

endmodule
